display_sequencer: RTL and testbench

DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

---
 rtl/display_pkg.sv | 26 ++
 rtl/display_sequencer_if.sv | 43 ++++
 rtl/hold_timer.sv | 47 ++++
 rtl/display_sequencer.sv | 124 ++++++++++++
 tb/tb_display_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg : shared state encoding, default sizes and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int DEF_NUM_W    = 4;
  localparam int DEF_NUM_N    = 4;
  localparam int DEF_HOLD_CYC = 700;

  // Counter/index width for a range of n values, never narrower than 1 bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_sequencer_if.sv
// ============================================================================
// display_sequencer_if : request/data/status bundle of the display sequencer
// Rev 1.0   (repeat_en present only when DISPLAY_SEQ_REPEAT_EN is defined)
// ============================================================================
`default_nettype none

interface display_sequencer_if
  import display_pkg::*;
#(
  parameter int NUM_W = DEF_NUM_W,
  parameter int NUM_N = DEF_NUM_N
);

  logic                   start_display;
  logic                   rev;
  logic [NUM_N*NUM_W-1:0] sorted_num;
`ifdef DISPLAY_SEQ_REPEAT_EN
  logic                   repeat_en;
`endif
  logic [NUM_W-1:0]       partE;
  logic                   partE_valid;
  logic                   busy;
  logic                   done;

  modport master (
`ifdef DISPLAY_SEQ_REPEAT_EN
    output repeat_en,
`endif
    output start_display, rev, sorted_num,
    input  partE, partE_valid, busy, done
  );

  modport slave (
`ifdef DISPLAY_SEQ_REPEAT_EN
    input  repeat_en,
`endif
    input  start_display, rev, sorted_num,
    output partE, partE_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/hold_timer.sv
// ============================================================================
// hold_timer : counts 0..HOLD_CYC-1 while enabled, flags the last count
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_timer
  import display_pkg::*;
#(
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW       = width_of(HOLD_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Self-wrapping at the last count, so the next entry starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/display_sequencer.sv
// ============================================================================
// display_sequencer : shows a captured frame one entry at a time, HOLD_CYC each
// Rev 1.0   Optional: DISPLAY_SEQ_REPEAT_EN adds repeat_en (continuous wrap)
// ============================================================================
`default_nettype none

module display_sequencer
  import display_pkg::*;
#(
  parameter int NUM_W    = DEF_NUM_W,
  parameter int NUM_N    = DEF_NUM_N,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  display_sequencer_if.slave bus
);

  localparam int            IW       = width_of(NUM_N);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_N - 1);

  state_e                 state_q;
  logic [NUM_N*NUM_W-1:0] frame_q;
  logic                   rev_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_W-1:0]       partE_q;
  logic                   partE_valid_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   show_w;
  logic                   accept_w;
  logic                   expire_w;
  logic                   repeat_w;
  logic                   last_w;
  logic [IW-1:0]          start_idx_d;
  logic [IW-1:0]          idx_d;

  assign show_w   = (state_q == SHOW);
  assign accept_w = (state_q == IDLE) && bus.start_display;

`ifdef DISPLAY_SEQ_REPEAT_EN
  assign repeat_w = bus.repeat_en;
`else
  assign repeat_w = 1'b0;
`endif

  hold_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_w),
    .en     (show_w),
    .expire (expire_w)
  );

  // Next index wraps to the first entry of the same order after the final one.
  always_comb begin
    start_idx_d = bus.rev ? IDX_LAST : '0;
    last_w      = rev_q ? (idx_q == '0) : (idx_q == IDX_LAST);
    if (last_w) begin
      idx_d = rev_q ? IDX_LAST : '0;
    end else begin
      idx_d = rev_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      rev_q         <= 1'b0;
      idx_q         <= '0;
      partE_q       <= '0;
      partE_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_display) begin
            frame_q       <= bus.sorted_num;
            rev_q         <= bus.rev;
            idx_q         <= start_idx_d;
            partE_q       <= bus.sorted_num[int'(start_idx_d)*NUM_W +: NUM_W];
            partE_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= SHOW;
          end
        end
        SHOW: begin
          if (expire_w) begin
            if (last_w && !repeat_w) begin
              partE_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= FIN;
            end else begin
              idx_q   <= idx_d;
              partE_q <= frame_q[int'(idx_d)*NUM_W +: NUM_W];
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.partE       = partE_q;
  assign bus.partE_valid = partE_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_display_sequencer.sv
// ============================================================================
// tb_display_sequencer : directed table plus hand sequences, NUM_N=4 HOLD_CYC=3
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_sequencer;

  logic clk;
  logic rst_n;

  display_sequencer_if #(.NUM_W(4), .NUM_N(4)) bus ();

  display_sequencer #(
    .NUM_W    (4),
    .NUM_N    (4),
    .HOLD_CYC (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        rev;
    logic [15:0] num;
    logic [3:0]  pe;
    logic        v;
    logic        b;
    logic        d;
  } vec_t;

  vec_t vecs [28];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] n,
                              input logic [3:0] pe, input logic v, input logic b,
                              input logic d);
    vec_t t;
    t.start = s; t.rev = r; t.num = n; t.pe = pe; t.v = v; t.b = b; t.d = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] pe, input logic v,
                         input logic b, input logic d);
    chk({tag, "_partE"}, 32'(bus.partE), 32'(pe));
    chk({tag, "_valid"}, 32'(bus.partE_valid), 32'(v));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.done && cyc < limit);
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    int  cyc;
    logic saw;
    n_checks = 0;
    n_fail   = 0;

    // Row k: inputs applied before an edge, expected outputs after that edge.
    vecs[0]  = mk(1, 0, 16'h9531, 4'h1, 1, 1, 0);
    vecs[1]  = mk(0, 0, 16'h9531, 4'h1, 1, 1, 0);
    vecs[2]  = mk(0, 0, 16'h9531, 4'h1, 1, 1, 0);
    vecs[3]  = mk(0, 0, 16'h9531, 4'h3, 1, 1, 0);
    vecs[4]  = mk(0, 0, 16'h9531, 4'h3, 1, 1, 0);
    vecs[5]  = mk(0, 0, 16'h9531, 4'h3, 1, 1, 0);
    vecs[6]  = mk(0, 0, 16'h9531, 4'h5, 1, 1, 0);
    vecs[7]  = mk(0, 0, 16'h9531, 4'h5, 1, 1, 0);
    vecs[8]  = mk(0, 0, 16'h9531, 4'h5, 1, 1, 0);
    vecs[9]  = mk(0, 0, 16'h9531, 4'h9, 1, 1, 0);
    vecs[10] = mk(0, 0, 16'h9531, 4'h9, 1, 1, 0);
    vecs[11] = mk(0, 0, 16'h9531, 4'h9, 1, 1, 0);
    vecs[12] = mk(0, 0, 16'h9531, 4'h9, 0, 1, 1);
    vecs[13] = mk(0, 0, 16'h9531, 4'h9, 0, 0, 0);
    vecs[14] = mk(1, 1, 16'h9531, 4'h9, 1, 1, 0);
    vecs[15] = mk(0, 1, 16'hFFFF, 4'h9, 1, 1, 0);
    vecs[16] = mk(1, 0, 16'hFFFF, 4'h9, 1, 1, 0);
    vecs[17] = mk(1, 1, 16'hFFFF, 4'h5, 1, 1, 0);
    vecs[18] = mk(0, 1, 16'h9531, 4'h5, 1, 1, 0);
    vecs[19] = mk(0, 1, 16'h9531, 4'h5, 1, 1, 0);
    vecs[20] = mk(1, 0, 16'hFFFF, 4'h3, 1, 1, 0);
    vecs[21] = mk(0, 1, 16'hFFFF, 4'h3, 1, 1, 0);
    vecs[22] = mk(0, 1, 16'h9531, 4'h3, 1, 1, 0);
    vecs[23] = mk(0, 1, 16'h9531, 4'h1, 1, 1, 0);
    vecs[24] = mk(0, 1, 16'hFFFF, 4'h1, 1, 1, 0);
    vecs[25] = mk(0, 1, 16'h9531, 4'h1, 1, 1, 0);
    vecs[26] = mk(1, 1, 16'h9531, 4'h1, 0, 1, 1);
    vecs[27] = mk(1, 0, 16'h9531, 4'h1, 0, 0, 0);

    rst_n             = 1'b0;
    bus.start_display = 1'b0;
    bus.rev           = 1'b0;
    bus.sorted_num    = 16'h9531;
`ifdef DISPLAY_SEQ_REPEAT_EN
    bus.repeat_en     = 1'b0;
`endif
    step();
    step();
    chk_out("reset", 4'h0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 4'h0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      bus.start_display = vecs[i].start;
      bus.rev           = vecs[i].rev;
      bus.sorted_num    = vecs[i].num;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].pe, vecs[i].v, vecs[i].b, vecs[i].d);
    end
    bus.start_display = 1'b0;
    bus.rev           = 1'b0;
    bus.sorted_num    = 16'h9531;
    step();
    chk_out("no_pass_from_fin_start", 4'h1, 0, 0, 0);

    // Mid-pass reset at cycle 5, with start asserted on the same edge.
    bus.start_display = 1'b1;
    step();
    bus.start_display = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_out("pre_reset_c4", 4'h3, 1, 1, 0);
    rst_n             = 1'b0;
    bus.start_display = 1'b1;
    step();
    chk_out("midpass_reset", 4'h0, 0, 0, 0);
    rst_n             = 1'b1;
    bus.start_display = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done || bus.busy) saw = 1'b1;
    end
    chk("post_reset_quiet", 32'(saw), 32'd0);

    // Back-to-back with start held high.
    bus.start_display = 1'b1;
    wait_done("b2b_first", 30, cyc);
    chk("b2b_first_done_cycle", 32'(cyc), 32'd13);
    step();
    chk_out("b2b_gap", 4'h9, 0, 0, 0);
    step();
    chk_out("b2b_second_start", 4'h1, 1, 1, 0);
    bus.start_display = 1'b0;
    wait_done("b2b_second", 30, cyc);
    chk("b2b_second_done_cycle", 32'(cyc), 32'd12);
    step();
    chk_out("b2b_end_idle", 4'h9, 0, 0, 0);

`ifdef DISPLAY_SEQ_REPEAT_EN
    bus.repeat_en     = 1'b1;
    bus.start_display = 1'b1;
    step();
    bus.start_display = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk_out("rep_c12", 4'h9, 1, 1, 0);
    step();
    chk_out("rep_wrap_c13", 4'h1, 1, 1, 0);
    for (int i = 0; i < 9; i++) step();
    chk_out("rep_c22", 4'h9, 1, 1, 0);
    step();
    bus.repeat_en = 1'b0;
    step();
    chk_out("rep_c24", 4'h9, 1, 1, 0);
    step();
    chk_out("rep_fin_c25", 4'h9, 0, 1, 1);
    step();
    chk_out("rep_idle_c26", 4'h9, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
